// File: rtl/spatial_encoder.sv
// ---------------------------------------------------------------------------
// spatial_encoder
//
// Purpose:
//   Consumes the per-modality im/projm beat stream. Each accepted beat is
//   bound as im ^ projm and folded into per-bit vote counters. After the last
//   channel of a sample, the block emits one majority-bundled spatial
//   hypervector through a valid/ready handshake.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-low reset
//   im           in   item-memory HV for the current channel
//   projm        in   projection HV; all-zero marks an inactive channel
//   din_valid    in   beat present
//   din_ready    out  beat accepted when din_valid && din_ready
//   spatial_hv   out  bundled result (strict majority, tie -> 0)
//   active_count out  number of active (non-zero projm) beats in the sample
//   dout_valid   out  result available
//   dout_ready   in   downstream accepts; transfer when valid && ready
// ---------------------------------------------------------------------------
module spatial_encoder #(
    parameter int HV_DIMENSION = 2000,
    parameter int NUM_CHANNEL  = 32,
    parameter int CNT_WIDTH    = $clog2(NUM_CHANNEL + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [HV_DIMENSION-1:0] im,
    input  logic [HV_DIMENSION-1:0] projm,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [HV_DIMENSION-1:0] spatial_hv,
    output logic [CNT_WIDTH-1:0]    active_count,
    output logic                    dout_valid,
    input  logic                    dout_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(NUM_CHANNEL - 1);

    state_t                                   state_q, state_d;
    logic [HV_DIMENSION-1:0][CNT_WIDTH-1:0]   vote_q, vote_d, vote_next;
    logic [CNT_WIDTH-1:0]                     active_q, active_d, active_next;
    logic [CNT_WIDTH-1:0]                     beat_cnt_q, beat_cnt_d;
    logic [HV_DIMENSION-1:0]                  spatial_hv_q, spatial_hv_d;
    logic [CNT_WIDTH-1:0]                     active_count_q, active_count_d;

    logic [HV_DIMENSION-1:0] bound;
    logic                    is_active;
    logic                    beat;
    logic                    last_beat;

    assign dout_valid   = (state_q == DONE);
    assign din_ready    = !dout_valid;
    assign spatial_hv   = spatial_hv_q;
    assign active_count = active_count_q;

    assign bound     = im ^ projm;
    assign is_active = |projm;
    assign beat      = din_valid && din_ready;
    assign last_beat = beat && (beat_cnt_q == LAST_BEAT);

    always_comb begin
        state_d        = state_q;
        vote_d         = vote_q;
        vote_next      = vote_q;
        active_d       = active_q;
        active_next    = active_q;
        beat_cnt_d     = beat_cnt_q;
        spatial_hv_d   = spatial_hv_q;
        active_count_d = active_count_q;

        // Inactive channels still count as a beat but leave the votes alone.
        if (is_active) begin
            for (int k = 0; k < HV_DIMENSION; k++) begin
                vote_next[k] = vote_q[k] + CNT_WIDTH'(bound[k]);
            end
            active_next = active_q + CNT_ONE;
        end

        if (beat) begin
            if (last_beat) begin
                // Compare one bit wider so 2*vote cannot overflow; with
                // active == 0 every vote is 0 and the result is all-zero.
                for (int k = 0; k < HV_DIMENSION; k++) begin
                    spatial_hv_d[k] = ({vote_next[k], 1'b0} > {1'b0, active_next});
                end
                active_count_d = active_next;
                vote_d         = '0;
                active_d       = '0;
                beat_cnt_d     = '0;
                state_d        = DONE;
            end else begin
                vote_d     = vote_next;
                active_d   = active_next;
                beat_cnt_d = beat_cnt_q + CNT_ONE;
                state_d    = ACCUM;
            end
        end else if ((state_q == DONE) && dout_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            vote_q         <= '0;
            active_q       <= '0;
            beat_cnt_q     <= '0;
            spatial_hv_q   <= '0;
            active_count_q <= '0;
        end else begin
            state_q        <= state_d;
            vote_q         <= vote_d;
            active_q       <= active_d;
            beat_cnt_q     <= beat_cnt_d;
            spatial_hv_q   <= spatial_hv_d;
            active_count_q <= active_count_d;
        end
    end

endmodule

// File: tb/tb_spatial_encoder.sv
// ---------------------------------------------------------------------------
// tb_spatial_encoder
//
// Two instances at HV_DIMENSION=8: dut3 (NUM_CHANNEL=3) and dut4
// (NUM_CHANNEL=4, tie-break case). Expected results are pushed into a queue
// per instance when a sample is issued; a monitor per instance pops and
// compares on each output transfer.
// ---------------------------------------------------------------------------
module tb_spatial_encoder;

    typedef struct {
        logic [7:0] hv;
        logic [3:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst;

    logic [7:0] im3, projm3, spatial_hv3;
    logic       din_valid3, din_ready3, dout_valid3, dout_ready3;
    logic [1:0] active_count3;

    logic [7:0] im4, projm4, spatial_hv4;
    logic       din_valid4, din_ready4, dout_valid4, dout_ready4;
    logic [2:0] active_count4;

    int   vectors;
    int   miscompares;
    int   cyc;
    int   last_fire_cyc;
    int   fire_gap;
    exp_t exp_q3[$];
    exp_t exp_q4[$];

    spatial_encoder #(.HV_DIMENSION(8), .NUM_CHANNEL(3)) dut3 (
        .clk(clk), .rst(rst), .im(im3), .projm(projm3),
        .din_valid(din_valid3), .din_ready(din_ready3),
        .spatial_hv(spatial_hv3), .active_count(active_count3),
        .dout_valid(dout_valid3), .dout_ready(dout_ready3)
    );

    spatial_encoder #(.HV_DIMENSION(8), .NUM_CHANNEL(4)) dut4 (
        .clk(clk), .rst(rst), .im(im4), .projm(projm4),
        .din_valid(din_valid4), .din_ready(din_ready4),
        .spatial_hv(spatial_hv4), .active_count(active_count4),
        .dout_valid(dout_valid4), .dout_ready(dout_ready4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one beat into dut3, waiting (bounded) for din_ready first.
    task automatic apply_stimulus(input logic [7:0] im_v, input logic [7:0] projm_v);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!din_ready3 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check_output("din_ready3_timeout", 0, 1);
        im3        = im_v;
        projm3     = projm_v;
        din_valid3 = 1'b1;
        @(posedge clk);
        #1 din_valid3 = 1'b0;
    endtask

    task automatic apply_stimulus4(input logic [7:0] im_v, input logic [7:0] projm_v);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!din_ready4 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check_output("din_ready4_timeout", 0, 1);
        im4        = im_v;
        projm4     = projm_v;
        din_valid4 = 1'b1;
        @(posedge clk);
        #1 din_valid4 = 1'b0;
    endtask

    // Monitors: compare on every output transfer.
    always @(negedge clk) begin
        if (rst && dout_valid3 && dout_ready3) begin
            if (exp_q3.size() == 0) begin
                check_output("dut3_unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = exp_q3.pop_front();
                check_output("dut3_spatial_hv", int'(spatial_hv3), int'(e.hv));
                check_output("dut3_active_count", int'(active_count3), int'(e.cnt));
            end
            fire_gap      = cyc - last_fire_cyc;
            last_fire_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        if (rst && dout_valid4 && dout_ready4) begin
            if (exp_q4.size() == 0) begin
                check_output("dut4_unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = exp_q4.pop_front();
                check_output("dut4_spatial_hv", int'(spatial_hv4), int'(e.hv));
                check_output("dut4_active_count", int'(active_count4), int'(e.cnt));
            end
        end
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        cyc           = 0;
        last_fire_cyc = 0;
        fire_gap      = 0;
        rst           = 1'b0;
        im3 = '0; projm3 = '0; din_valid3 = 1'b0; dout_ready3 = 1'b1;
        im4 = '0; projm4 = '0; din_valid4 = 1'b0; dout_ready4 = 1'b1;

        // Reset state
        #1;
        check_output("reset_dout_valid", int'(dout_valid3), 0);
        check_output("reset_spatial_hv", int'(spatial_hv3), 0);
        check_output("reset_active_count", int'(active_count3), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("reset_din_ready", int'(din_ready3), 1);

        // 1: basic majority, latency of one cycle after the third beat
        exp_q3.push_back('{hv: 8'hF0, cnt: 4'd3});
        apply_stimulus(8'hFF, 8'h0F);
        apply_stimulus(8'hFF, 8'h0F);
        check_output("s1_valid_before_last", int'(dout_valid3), 0);
        apply_stimulus(8'hFF, 8'h0F);
        check_output("s1_valid_after_last", int'(dout_valid3), 1);
        check_output("s1_din_ready_done", int'(din_ready3), 0);

        // 2: all inactive
        exp_q3.push_back('{hv: 8'h00, cnt: 4'd0});
        repeat (3) apply_stimulus(8'hA5, 8'h00);

        // 3: tie-break on the 4-channel instance, bound FF, FF, 0F, 00
        exp_q4.push_back('{hv: 8'h0F, cnt: 4'd4});
        apply_stimulus4(8'hF0, 8'h0F);
        apply_stimulus4(8'hF0, 8'h0F);
        apply_stimulus4(8'hFF, 8'hF0);
        apply_stimulus4(8'h5A, 8'h5A);

        // 4: backpressure with junk beats offered while held
        @(negedge clk);
        dout_ready3 = 1'b0;
        exp_q3.push_back('{hv: 8'hF0, cnt: 4'd3});
        repeat (3) apply_stimulus(8'hFF, 8'h0F);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            im3 = 8'h00; projm3 = 8'hFF; din_valid3 = 1'b1;
            check_output("s4_din_ready_held", int'(din_ready3), 0);
            check_output("s4_dout_valid_held", int'(dout_valid3), 1);
            check_output("s4_spatial_hv_held", int'(spatial_hv3), 'hF0);
            check_output("s4_active_count_held", int'(active_count3), 3);
        end
        @(negedge clk);
        din_valid3  = 1'b0;
        dout_ready3 = 1'b1;
        exp_q3.push_back('{hv: 8'h0F, cnt: 4'd3});
        repeat (3) apply_stimulus(8'h00, 8'h0F);

        // 5: reset mid-sample discards the partial sample
        apply_stimulus(8'hFF, 8'h0F);
        apply_stimulus(8'hFF, 8'h0F);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("s5_dout_valid_rst", int'(dout_valid3), 0);
        check_output("s5_spatial_hv_rst", int'(spatial_hv3), 0);
        check_output("s5_active_count_rst", int'(active_count3), 0);
        @(negedge clk);
        rst = 1'b1;
        exp_q3.push_back('{hv: 8'hF0, cnt: 4'd3});
        repeat (3) apply_stimulus(8'hFF, 8'h0F);

        // 6: back-to-back samples with dout_ready tied high
        exp_q3.push_back('{hv: 8'h0F, cnt: 4'd3});
        exp_q3.push_back('{hv: 8'hF0, cnt: 4'd3});
        repeat (3) apply_stimulus(8'h00, 8'h0F);
        repeat (3) apply_stimulus(8'h00, 8'hF0);
        repeat (2) @(negedge clk);
        check_output("s6_fire_gap", fire_gap, 4);

        // Drain: every issued sample must have produced its output
        for (int i = 0; i < 50 && (exp_q3.size() != 0 || exp_q4.size() != 0); i++) begin
            @(negedge clk);
        end
        check_output("dut3_queue_drained", exp_q3.size(), 0);
        check_output("dut4_queue_drained", exp_q4.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
